br_pred_gshare: RTL and testbench

- Parametrised successor to the current 2-bit/BHR branch predictor; sits beside the IF stage and is updated from EX.
- Adds a gshare-indexed pattern history table (PC xor global history) and a tagged, direct-mapped BTB.
- Keeps a speculative global history register with checkpoint-based recovery on mispredict, plus a saturating mispredict counter.

---
 rtl/br_pred_gshare_pkg.sv | 48 ++++
 rtl/br_pred_gshare_if.sv | 34 +++
 rtl/br_pred_gshare_btb.sv | 62 ++++++
 rtl/br_pred_gshare.sv | 110 +++++++++++
 tb/tb_br_pred_gshare.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/br_pred_gshare_pkg.sv
// Shared RV32I encodings and branch-predictor types: the 2-bit saturating
// counter, the prediction metadata layout and the counter update rule.
package rv32i_types;
    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

package br_pred_gshare_pkg;
    localparam int BP_GHR_W   = 8;
    localparam int BP_PHT_IDX = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } sat_ctr_t;

    typedef struct packed {
        logic [BP_PHT_IDX-1:0] pht_idx;
        logic [BP_GHR_W-1:0]   ghr;
    } bp_meta_t;

    function automatic sat_ctr_t sat_next(input sat_ctr_t ctr, input logic taken);
        sat_ctr_t nxt;
        nxt = ctr;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction
endpackage

// File: rtl/br_pred_gshare_if.sv
// Fetch-side prediction and EX-side resolution signals of the gshare predictor.
interface br_pred_gshare_if #(
    parameter int PHT_IDX = 8,
    parameter int GHR_W   = 8
);
    import rv32i_types::*;

    logic                     if_valid;
    logic                     if_stall;
    rv32i_word                if_pc;
    logic                     pred_taken;
    rv32i_word                pred_target;
    logic [PHT_IDX+GHR_W-1:0] pred_meta;
    logic                     ex_valid;
    rv32i_opcode              ex_opcode;
    rv32i_word                ex_pc;
    logic                     ex_taken;
    rv32i_word                ex_target;
    logic [PHT_IDX+GHR_W-1:0] ex_meta;
    logic                     ex_mispredict;
    logic [31:0]              mispred_count;

    modport master (
        output if_valid, if_stall, if_pc,
        output ex_valid, ex_opcode, ex_pc, ex_taken, ex_target, ex_meta, ex_mispredict,
        input  pred_taken, pred_target, pred_meta, mispred_count
    );

    modport slave (
        input  if_valid, if_stall, if_pc,
        input  ex_valid, ex_opcode, ex_pc, ex_taken, ex_target, ex_meta, ex_mispredict,
        output pred_taken, pred_target, pred_meta, mispred_count
    );
endinterface

// File: rtl/br_pred_gshare_btb.sv
// Tagged direct-mapped branch target buffer: combinational lookup, synchronous write.
module bp_btb #(
    parameter int BTB_IDX = 4,
    parameter int TAG_W   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target
);
    localparam int ENTRIES = 2 ** BTB_IDX;

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];

    logic [BTB_IDX-1:0] rd_idx_s;
    logic [BTB_IDX-1:0] wr_idx_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [TAG_W-1:0]   wr_tag_s;
    logic               unused_pc_s;

    assign rd_idx_s    = lookup_pc[2 +: BTB_IDX];
    assign rd_tag_s    = lookup_pc[2 + BTB_IDX +: TAG_W];
    assign wr_idx_s    = wr_pc[2 +: BTB_IDX];
    assign wr_tag_s    = wr_pc[2 + BTB_IDX +: TAG_W];
    assign unused_pc_s = ^{lookup_pc, wr_pc};

    // Lookup reads pre-write contents; a same-cycle write is seen next cycle.
    always_comb begin
        hit    = 1'b0;
        target = target_r[rd_idx_s];
        if (valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    // Valid bits: cleared on reset, set on allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and target storage; qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_r[wr_idx_s]    <= wr_tag_s;
            target_r[wr_idx_s] <= wr_target;
        end
    end
endmodule

// File: rtl/br_pred_gshare.sv
// Gshare branch predictor: PC^GHR indexed counter table, tagged BTB, speculative
// global history with checkpoint recovery and a saturating mispredict counter.
module br_pred_gshare
    import rv32i_types::*;
    import br_pred_gshare_pkg::*;
#(
    parameter int GHR_W   = 8,
    parameter int PHT_IDX = 8,
    parameter int BTB_IDX = 4,
    parameter int TAG_W   = 12
) (
    input logic             clk,
    input logic             rst,
    br_pred_gshare_if.slave bus
);
    localparam int PHT_ENTRIES = 2 ** PHT_IDX;

    sat_ctr_t           pht_r [PHT_ENTRIES];
    logic [GHR_W-1:0]   ghr_r;
    logic [31:0]        mispred_count_r;

    logic [PHT_IDX-1:0] pht_idx_s;
    logic [1:0]         ctr_s;
    logic               btb_hit_s;
    logic [31:0]        btb_target_s;
    logic               pred_taken_s;
    logic               upd_s;
    logic               recover_s;
    logic               btb_wr_s;
    logic [PHT_IDX-1:0] ex_pht_idx_s;
    logic [GHR_W-1:0]   ex_ghr_s;
    logic               unused_meta_s;

    assign ex_pht_idx_s  = bus.ex_meta[GHR_W +: PHT_IDX];
    assign ex_ghr_s      = bus.ex_meta[GHR_W-1:0];
    assign unused_meta_s = ex_ghr_s[GHR_W-1];

    bp_btb #(
        .BTB_IDX (BTB_IDX),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (bus.if_pc),
        .hit       (btb_hit_s),
        .target    (btb_target_s),
        .wr_en     (btb_wr_s),
        .wr_pc     (bus.ex_pc),
        .wr_target (bus.ex_target)
    );

    // Fetch-side prediction, combinational from registered state.
    always_comb begin
        pht_idx_s    = bus.if_pc[2 +: PHT_IDX] ^ PHT_IDX'(ghr_r);
        ctr_s        = pht_r[pht_idx_s];
        pred_taken_s = bus.if_valid && btb_hit_s && ctr_s[1];
        if (pred_taken_s) begin
            bus.pred_target = btb_target_s;
        end else begin
            bus.pred_target = bus.if_pc + 32'd4;
        end
        bus.pred_taken    = pred_taken_s;
        bus.pred_meta     = {pht_idx_s, ghr_r};
        bus.mispred_count = mispred_count_r;
    end

    // Update qualification: only resolved conditional branches touch state.
    always_comb begin
        upd_s     = bus.ex_valid && (bus.ex_opcode == op_br);
        recover_s = upd_s && bus.ex_mispredict;
        btb_wr_s  = upd_s && bus.ex_taken;
    end

    // Pattern history table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= WNT;
            end
        end else if (upd_s) begin
            pht_r[ex_pht_idx_s] <= sat_next(pht_r[ex_pht_idx_s], bus.ex_taken);
        end else begin
            pht_r[ex_pht_idx_s] <= pht_r[ex_pht_idx_s];
        end
    end

    // Global history: recovery from the checkpoint wins over a speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= {GHR_W{1'b0}};
        end else if (recover_s) begin
            ghr_r <= {ex_ghr_s[GHR_W-2:0], bus.ex_taken};
        end else if (bus.if_valid && !bus.if_stall && btb_hit_s) begin
            ghr_r <= {ghr_r[GHR_W-2:0], pred_taken_s};
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_count_r <= 32'd0;
        end else if (recover_s && (mispred_count_r != 32'hFFFF_FFFF)) begin
            mispred_count_r <= mispred_count_r + 32'd1;
        end else begin
            mispred_count_r <= mispred_count_r;
        end
    end
endmodule

// File: tb/tb_br_pred_gshare.sv
// Directed self-checking bench for br_pred_gshare with hand-computed expectations.
module tb_br_pred_gshare;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    br_pred_gshare_if bus ();

    br_pred_gshare dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_upd(input rv32i_opcode op, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic [15:0] meta, input logic mis);
        bus.ex_valid      = 1'b1;
        bus.ex_opcode     = op;
        bus.ex_pc         = pc;
        bus.ex_taken      = tk;
        bus.ex_target     = tgt;
        bus.ex_meta       = meta;
        bus.ex_mispredict = mis;
        step();
        bus.ex_valid      = 1'b0;
        bus.ex_mispredict = 1'b0;
        bus.ex_opcode     = op_br;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic exp_tk,
                         input logic [31:0] exp_tgt, input logic [15:0] exp_meta, input logic keep);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        #1;
        chk({tag, "_taken"},  {31'd0, bus.pred_taken}, {31'd0, exp_tk});
        chk({tag, "_target"}, bus.pred_target, exp_tgt);
        chk({tag, "_meta"},   {16'd0, bus.pred_meta}, {16'd0, exp_meta});
        bus.if_valid = keep;
    endtask

    initial begin
        bus.if_valid      = 1'b0;
        bus.if_stall      = 1'b0;
        bus.if_pc         = 32'd0;
        bus.ex_valid      = 1'b0;
        bus.ex_opcode     = op_br;
        bus.ex_pc         = 32'd0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = 32'd0;
        bus.ex_meta       = 16'd0;
        bus.ex_mispredict = 1'b0;
        step();
        step();
        rst = 1'b0;

        // 1: reset state
        chk("t1_count", bus.mispred_count, 32'd0);
        probe("t1", 32'h100, 1'b0, 32'h104, 16'h4000, 1'b0);

        // 2: two taken mispredicts train index 0x41; recovery leaves GHR=0x01
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4100, 1'b1);
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4100, 1'b1);
        chk("t2_count", bus.mispred_count, 32'd2);
        probe("t2", 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        bus.if_pc = 32'h100;
        #1;
        chk("t2_novalid_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("t2_novalid_target", bus.pred_target, 32'h104);

        // 3: saturation at ST and SNT on index 0x41
        repeat (5) ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        probe("t3_st", 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        ex_upd(op_br, 32'h100, 1'b0, 32'h0, 16'h4101, 1'b0);
        probe("t3_wt", 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        chk("t3_count", bus.mispred_count, 32'd2);
        ex_upd(op_br, 32'h100, 1'b0, 32'h0, 16'h4101, 1'b0);
        probe("t3_wnt", 32'h100, 1'b0, 32'h104, 16'h4101, 1'b0);
        repeat (3) ex_upd(op_br, 32'h100, 1'b0, 32'h0, 16'h4101, 1'b0);
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        probe("t3_snt_up1", 32'h100, 1'b0, 32'h104, 16'h4101, 1'b0);
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);
        probe("t3_snt_up2", 32'h100, 1'b1, 32'h80, 16'h4101, 1'b0);

        // 4: speculative history, then recovery beating a same-cycle shift
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4000, 1'b0);
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4000, 1'b0);
        ex_upd(op_br, 32'h200, 1'b0, 32'h0, 16'h1000, 1'b1);
        chk("t4_count3", bus.mispred_count, 32'd3);
        probe("t4_f0", 32'h100, 1'b1, 32'h80, 16'h4000, 1'b1);
        step();
        probe("t4_f1", 32'h100, 1'b1, 32'h80, 16'h4101, 1'b1);
        step();
        probe("t4_ghr3", 32'h100, 1'b0, 32'h104, 16'h4303, 1'b1);
        ex_upd(op_br, 32'h100, 1'b0, 32'h0, 16'h4300, 1'b1);
        bus.if_valid = 1'b0;
        probe("t4_recov", 32'h100, 1'b1, 32'h80, 16'h4000, 1'b0);
        chk("t4_count4", bus.mispred_count, 32'd4);

        // 5: BTB alias on index 0
        probe("t5_alias", 32'h500, 1'b0, 32'h504, 16'h4000, 1'b0);
        ex_upd(op_br, 32'h500, 1'b1, 32'h900, 16'h4000, 1'b0);
        probe("t5_old", 32'h100, 1'b0, 32'h104, 16'h4000, 1'b0);
        probe("t5_new", 32'h500, 1'b1, 32'h900, 16'h4000, 1'b0);

        // 6: stall, non-branch resolve, reset over a pending mispredict
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h500;
        bus.if_stall = 1'b1;
        step();
        bus.if_stall = 1'b0;
        bus.if_valid = 1'b0;
        probe("t6_stall", 32'h500, 1'b1, 32'h900, 16'h4000, 1'b0);
        ex_upd(op_imm, 32'h500, 1'b0, 32'h0, 16'h4055, 1'b1);
        chk("t6_nonbr_count", bus.mispred_count, 32'd4);
        probe("t6_nonbr", 32'h500, 1'b1, 32'h900, 16'h4000, 1'b0);
        rst = 1'b1;
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h4055, 1'b1);
        rst = 1'b0;
        chk("t6_rst_count", bus.mispred_count, 32'd0);
        probe("t6_rst_500", 32'h500, 1'b0, 32'h504, 16'h4000, 1'b0);
        probe("t6_rst_100", 32'h100, 1'b0, 32'h104, 16'h4000, 1'b0);
        ex_upd(op_br, 32'h100, 1'b1, 32'h80, 16'h7F00, 1'b0);
        probe("t6_rst_pht", 32'h100, 1'b0, 32'h104, 16'h4000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
